// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: steps the AES round counter for 10/12/14-round keys and
// generates the round-register and output-register write enables for enc/dec.
module aes_round_sequencer #(
  parameter int MAX_ROUNDS    = 14,
  parameter int CNT_W         = 4,
  parameter bit ALLOW_OVERLAP = 1'b1
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inAesMode,
  input  logic [1:0]       inKeyLen,
  input  logic             inExtDataWr,
  output logic             outReady,
  output logic [CNT_W-1:0] outRound,
  output logic             outIntRoundRegExtEncWr,
  output logic             outIntRoundRegExtDecWr,
  output logic             outIntRoundRegIntEncWr,
  output logic             outIntRoundRegIntDecWr,
  output logic             outIntDataOutRegEncWr,
  output logic             outIntDataOutRegDecWr,
  output logic             outBusy,
  output logic             outDone
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seqState_t;

  localparam int               RESET_LAST_INT = (MAX_ROUNDS < 32'sd14) ? MAX_ROUNDS : 32'sd14;
  localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] RESET_LAST     = CNT_W'(RESET_LAST_INT);

  // Reserved key length 11 runs as AES-256; the result is clamped to MAX_ROUNDS.
  function automatic logic [CNT_W-1:0] roundsFor(input logic [1:0] keyLen);
    int n;
    case (keyLen)
      2'b00:   n = 32'sd10;
      2'b01:   n = 32'sd12;
      default: n = 32'sd14;
    endcase
    return (n > MAX_ROUNDS) ? CNT_W'(MAX_ROUNDS) : CNT_W'(n);
  endfunction

  logic [CNT_W-1:0] regCnt;
  logic [CNT_W-1:0] regLast;
  logic             regMode;
  logic             regDone;
  logic [CNT_W-1:0] nxtCnt;
  logic [CNT_W-1:0] nxtLast;
  logic             nxtMode;
  seqState_t        curState;
  logic             lastRound;
  logic             accept;
  logic             dataOutEnc;
  logic             dataOutDec;

  // Next-state decode: acceptance wins over the normal advance/return to idle.
  always_comb begin
    curState  = (regCnt == CNT_ZERO) ? IDLE : RUN;
    lastRound = (curState == RUN) && (regCnt == regLast);
    outReady  = (curState == IDLE) || (ALLOW_OVERLAP && lastRound);
    accept    = inExtDataWr && outReady;
    nxtCnt    = regCnt;
    nxtLast   = regLast;
    nxtMode   = regMode;
    if (accept) begin
      nxtCnt  = CNT_ONE;
      nxtLast = roundsFor(inKeyLen);
      nxtMode = inAesMode;
    end else begin
      case (curState)
        IDLE:    nxtCnt = CNT_ZERO;
        RUN:     nxtCnt = lastRound ? CNT_ZERO : (regCnt + CNT_ONE);
        default: nxtCnt = CNT_ZERO;
      endcase
    end
  end

  assign dataOutEnc = lastRound & ~regMode;
  assign dataOutDec = lastRound &  regMode;

  // Round counter, latched mode/length and the registered done pulse.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      regCnt  <= CNT_ZERO;
      regLast <= RESET_LAST;
      regMode <= 1'b0;
      regDone <= 1'b0;
    end else begin
      regCnt  <= nxtCnt;
      regLast <= nxtLast;
      regMode <= nxtMode;
      regDone <= dataOutEnc | dataOutDec;
    end
  end

  // Ext strobes use the live mode so a new block can load during an overlap cycle.
  assign outIntRoundRegExtEncWr = accept & ~inAesMode;
  assign outIntRoundRegExtDecWr = accept &  inAesMode;
  assign outIntRoundRegIntEncWr = (curState == RUN) & ~regMode;
  assign outIntRoundRegIntDecWr = (curState == RUN) &  regMode;
  assign outIntDataOutRegEncWr  = dataOutEnc;
  assign outIntDataOutRegDecWr  = dataOutDec;
  assign outRound               = regCnt;
  assign outBusy                = (curState == RUN);
  assign outDone                = regDone;

endmodule
